// File: rtl/user_id_pkg.sv
// user_id_pkg
//   Shared types and constants for the user project ID access controller.
//   Contents:
//     state_t    - sequencing FSM states (RESET, SETTLE, CAPTURE, READY)
//     ID_W       - width of the ID / mask revision word
//     SEL_W      - width of a byte-select field
//     SER_CNT_W  - width of the serial shift bit counter
//     id_byte()  - extracts one byte of the ID word by byte index
package user_id_pkg;

    localparam int ID_W      = 32;
    localparam int SEL_W     = 2;
    localparam int SER_CNT_W = 5;

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READY   = 2'd3
    } state_t;

    // Byte 0 is bits 7:0, byte 3 is bits 31:24.
    function automatic logic [7:0] id_byte(input logic [ID_W-1:0] w,
                                           input logic [SEL_W-1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/user_id_rr_arb.sv
// user_id_rr_arb
//   Two-way round-robin arbiter. At most one grant per cycle; grants are
//   combinational from the requests. When both request, the requester that
//   was not granted most recently wins. After reset requester 0 (A) is
//   favoured.
//   Ports:
//     i_clk    - clock, rising edge
//     i_rst_n  - asynchronous active-low reset
//     i_en     - grants allowed this cycle
//     i_req    - [0] = requester A, [1] = requester B
//     o_gnt    - one-hot (or zero) grant, same bit order as i_req
module user_id_rr_arb (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    // 1 when B should win the next contention (A was granted last).
    logic r_prio_b;

    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            if (i_req[0] && (!i_req[1] || !r_prio_b)) begin
                o_gnt = 2'b01;
            end else if (i_req[1]) begin
                o_gnt = 2'b10;
            end
        end
    end

    // Pointer moves on every grant, including uncontended ones, so the
    // "most recently granted" history is always accurate.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prio_b <= 1'b0;
        end else if (o_gnt[0]) begin
            r_prio_b <= 1'b1;
        end else if (o_gnt[1]) begin
            r_prio_b <= 1'b0;
        end
    end

endmodule

// File: rtl/user_id_access_ctrl.sv
// user_id_access_ctrl
//   Captures the user project ID / mask revision word from the tie-cell
//   array after a settle interval and serves byte reads to two requesters
//   through a round-robin arbiter. An optional serial shifter streams the
//   captured word out MSB first.
//   Optional feature macro: USER_ID_SERIAL_EN (serial shifter present when
//   defined; otherwise ser_out_o / ser_busy_o are tied 0 and ser_start_i is
//   ignored).
//   Ports:
//     wb_clk_i      - clock, rising edge
//     wb_rstn_i     - asynchronous active-low reset
//     mask_rev_i    - raw 32-bit ID word (static)
//     recapture_i   - pulse: re-run settle and capture
//     ready_o       - shadow register valid
//     id_o          - shadow register
//     a_req_i/a_sel_i, b_req_i/b_sel_i - read requests and byte selects
//     a_gnt_o/b_gnt_o                  - combinational grants
//     a_valid_o/b_valid_o              - read data valid (cycle after grant)
//     a_rdata_o/b_rdata_o              - read data byte, held until next valid
//     ser_start_i   - start serial shift-out
//     ser_out_o     - serial data, MSB first
//     ser_busy_o    - shift in progress
module user_id_access_ctrl
    import user_id_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rstn_i,
    input  logic [ID_W-1:0]  mask_rev_i,
    input  logic             recapture_i,
    output logic             ready_o,
    output logic [ID_W-1:0]  id_o,
    input  logic             a_req_i,
    input  logic [SEL_W-1:0] a_sel_i,
    output logic             a_gnt_o,
    output logic             a_valid_o,
    output logic [7:0]       a_rdata_o,
    input  logic             b_req_i,
    input  logic [SEL_W-1:0] b_sel_i,
    output logic             b_gnt_o,
    output logic             b_valid_o,
    output logic [7:0]       b_rdata_o,
    input  logic             ser_start_i,
    output logic             ser_out_o,
    output logic             ser_busy_o
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t          r_state;
    logic [3:0]      r_settle_cnt;
    logic            r_ready;
    logic [ID_W-1:0] r_id;

    logic            r_a_valid;
    logic [7:0]      r_a_rdata;
    logic            r_b_valid;
    logic [7:0]      r_b_rdata;

    logic [1:0]      w_gnt;
    logic            w_ser_busy;
    logic            w_recap_pend;
    logic            w_recap_take;

    // A recapture (fresh or deferred) is only acted on in READY and never
    // while a shift is in flight.
    assign w_recap_take = (r_state == ST_READY) && (recapture_i || w_recap_pend) && !w_ser_busy;

    // ------------------------------------------------------------------
    // Sequencing FSM: RESET -> SETTLE -> CAPTURE -> READY
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_state      <= ST_RESET;
            r_settle_cnt <= 4'd0;
            r_ready      <= 1'b0;
            r_id         <= '0;
        end else begin
            case (r_state)
                ST_RESET: begin
                    r_state      <= ST_SETTLE;
                    r_settle_cnt <= 4'd0;
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    r_id    <= mask_rev_i;
                    r_ready <= 1'b1;
                    r_state <= ST_READY;
                end
                ST_READY: begin
                    if (w_recap_take) begin
                        r_state      <= ST_SETTLE;
                        r_settle_cnt <= 4'd0;
                        r_ready      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_RESET;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o = r_ready;
    assign id_o    = r_id;

    // ------------------------------------------------------------------
    // Arbitration and read data
    // ------------------------------------------------------------------
    user_id_rr_arb u_arb (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rstn_i),
        .i_en    (r_ready),
        .i_req   ({b_req_i, a_req_i}),
        .o_gnt   (w_gnt)
    );

    assign a_gnt_o = w_gnt[0];
    assign b_gnt_o = w_gnt[1];

    // Data is taken from the shadow as it stands during the grant cycle, so
    // a simultaneous recapture still returns the pre-recapture value.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_a_valid <= 1'b0;
            r_a_rdata <= 8'd0;
            r_b_valid <= 1'b0;
            r_b_rdata <= 8'd0;
        end else begin
            r_a_valid <= w_gnt[0];
            r_b_valid <= w_gnt[1];
            if (w_gnt[0]) begin
                r_a_rdata <= id_byte(r_id, a_sel_i);
            end
            if (w_gnt[1]) begin
                r_b_rdata <= id_byte(r_id, b_sel_i);
            end
        end
    end

    assign a_valid_o = r_a_valid;
    assign a_rdata_o = r_a_rdata;
    assign b_valid_o = r_b_valid;
    assign b_rdata_o = r_b_rdata;

    // ------------------------------------------------------------------
    // Serial shifter
    // ------------------------------------------------------------------
`ifdef USER_ID_SERIAL_EN
    logic                 r_ser_busy;
    logic [SER_CNT_W-1:0] r_ser_cnt;
    logic [ID_W-1:0]      r_ser_shreg;
    logic                 r_recap_pend;
    logic                 w_ser_start;

    assign w_ser_start = ser_start_i && (r_state == ST_READY) && !r_ser_busy;

    // The shift register holds a private copy of the ID so byte reads and
    // the shadow itself are independent of the shift.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_ser_busy   <= 1'b0;
            r_ser_cnt    <= '0;
            r_ser_shreg  <= '0;
            r_recap_pend <= 1'b0;
        end else begin
            if (w_ser_start) begin
                r_ser_shreg <= r_id;
                r_ser_cnt   <= '0;
                r_ser_busy  <= 1'b1;
            end else if (r_ser_busy) begin
                r_ser_shreg <= {r_ser_shreg[ID_W-2:0], 1'b0};
                r_ser_cnt   <= r_ser_cnt + 5'd1;
                if (r_ser_cnt == 5'd31) begin
                    r_ser_busy <= 1'b0;
                end
            end

            // Hold a recapture that arrives mid-shift until the shift ends.
            if (w_recap_take) begin
                r_recap_pend <= 1'b0;
            end else if (recapture_i && r_ser_busy) begin
                r_recap_pend <= 1'b1;
            end
        end
    end

    assign w_ser_busy   = r_ser_busy;
    assign w_recap_pend = r_recap_pend;
    assign ser_busy_o   = r_ser_busy;
    assign ser_out_o    = r_ser_busy & r_ser_shreg[ID_W-1];
`else
    logic w_unused_ser_start;

    assign w_unused_ser_start = ser_start_i;
    assign w_ser_busy         = 1'b0;
    assign w_recap_pend       = 1'b0;
    assign ser_busy_o         = 1'b0;
    assign ser_out_o          = 1'b0;
`endif

endmodule

// File: doc/user_id_access_ctrl.md
# user_id_access_ctrl

Sequencing and arbitration controller for the user project ID / mask revision word. After reset it waits a settle interval, then captures the 32-bit tie-cell word into a shadow register. Two byte-wide requesters (wishbone-side and housekeeping-SPI-side) share read access to that register through round-robin arbitration. An optional serial shifter streams the ID out for test. The block sits in housekeeping, between the ID tie-cell array and the register-read paths.

## Interface
- SETTLE_CYCLES, 4: cycles to wait after reset release or recapture before sampling `mask_rev_i` (1..15).
- wb_clk_i  in  1  sole clock, rising edge.
- wb_rstn_i  in  1  reset, asynchronous assert, active-low.
- mask_rev_i  in  32  raw ID word from the tie-cell array, static after power-up.
- recapture_i  in  1  single-cycle pulse; re-runs settle and capture.
- ready_o  out  1  shadow register valid; reads accepted only while high.
- id_o  out  32  shadow register.
- a_req_i  in  1  requester A read request, held until granted.
- a_sel_i  in  2  byte index for A (0 = bits 7:0 … 3 = bits 31:24).
- a_gnt_o  out  1  grant to A, combinational, one cycle per accepted read.
- a_valid_o  out  1  A read data valid, one-cycle pulse.
- a_rdata_o  out  8  A read data.
- b_req_i, b_sel_i, b_gnt_o, b_valid_o, b_rdata_o: same as A, for requester B.
- ser_start_i  in  1  start serial shift-out (`USER_ID_SERIAL_EN` only).
- ser_out_o  out  1  serial data, MSB first.
- ser_busy_o  out  1  shift in progress.

## Operation
- FSM states: RESET, SETTLE, CAPTURE, READY.
  - RESET: entered while wb_rstn_i = 0; moves to SETTLE on the first clock after release.
  - SETTLE: counter counts from 0 up to SETTLE_CYCLES-1, then moves to CAPTURE.
  - CAPTURE: `id_o <= mask_rev_i`, then moves to READY.
  - READY: `ready_o = 1`. A `recapture_i` pulse goes back to SETTLE and drops `ready_o` in the next cycle.
- Grants are issued only in READY. In any other state both `*_gnt_o` are 0 and requests stay pending.
- Arbitration:
  - A single request is granted in the same cycle.
  - If both request, the requester not granted most recently wins. The pointer resets to favour A, and at most one grant is issued per cycle.
  - If req is held after a grant, further grants follow back-to-back, alternating with the other requester when both are active.
- Read data: the cycle after a grant, `*_valid_o = 1` and `*_rdata_o = id_o[8*sel+7 : 8*sel]`, using the sel sampled at grant. Rdata holds its value until the next valid.
- Recapture on the same cycle as a grant: the grant completes and its data comes from the pre-recapture shadow.
- Recapture while `ser_busy_o` is high: the recapture is held pending and is taken in the cycle after the shift finishes.
- Reset mid-operation: state returns to RESET immediately and any pending valid, pending recapture or shift is discarded.
- Reset values: ready_o 0, id_o 0, all gnt/valid 0, all rdata 0, ser_out_o 0, ser_busy_o 0.

## Timing
- Reset release to `ready_o` high: SETTLE_CYCLES + 2 clocks (default 6).
- Grant to valid: 1 clock. Sustained throughput: 1 read per clock in total.
- Serial shift:
  - A `ser_start_i` seen in READY with not busy raises `ser_busy_o` the next cycle, with `ser_out_o = id_o[31]`.
  - Each following cycle presents the next lower bit. `ser_busy_o` is high for exactly 32 cycles.
  - `ser_start_i` while busy or not READY is ignored.
- The serial shifter copies `id_o` at start, so byte reads during a shift are unaffected.

## Configuration
- `USER_ID_SERIAL_EN` defined: the serial shifter is present and behaves as specified.
- Not defined: no shifter logic. `ser_start_i` is ignored, `ser_out_o` and `ser_busy_o` are tied 0, recapture is never deferred, and the ports remain present.

## Structure
- Shared package `user_id_pkg`:
  - FSM state enum (RESET, SETTLE, CAPTURE, READY).
  - ID width 32, byte-select width 2.
  - Serial count width 5.
- Sub-module `user_id_rr_arb`: 2-way round-robin arbiter with req/gnt and last-grant pointer. All remaining logic lives in the top.

## Test plan
- Reset release, mask_rev_i = 32'hA5C3_0F12, SETTLE_CYCLES = 4 -> ready_o rises at clock 6 and id_o = 32'hA5C3_0F12.
- A alone, a_sel_i = 2 -> a_gnt_o in the same cycle; next cycle a_valid_o = 1, a_rdata_o = 8'hC3.
- A and B both held, A sel 0, B sel 3 -> grants alternate A,B,A,B starting with A; rdata alternates 8'h12 / 8'hA5.
- Request while in SETTLE after recapture_i with mask_rev_i changed to 32'h0000_0001 -> no grant until ready; then data from the new ID (byte 0 = 8'h01).
- With `USER_ID_SERIAL_EN`, ser_start_i with id 32'h8000_0001 -> ser_out_o is 1, then 30 zeros, then 1; busy for 32 cycles; a recapture_i mid-shift is applied after the shift ends.
- wb_rstn_i asserted during a grant and during a shift -> all outputs read 0 immediately, with no valid pulse afterwards.
